// File: rtl/led_pattern_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: pattern mode encoding
// and the per-mode seed pattern.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'd0,
        MODE_ROT_R  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    // Starting pattern for a mode, LSB-aligned; callers truncate to their LED width.
    function automatic logic [15:0] led_seed(input logic [1:0] mode, input int led_w);
        case (mode)
            MODE_ROT_R: return 16'd1 << (led_w - 1);
            MODE_COUNT: return 16'd0;
            default:    return 16'd1;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_seq_if.sv
// Control and LED-output bundle between the board switch/button logic
// (master) and the LED pattern sequencer (slave).
interface led_pattern_seq_if #(
    parameter int LED_W = 4
);
    logic [1:0]       mode;
    logic             run;
    logic             step;
    logic [1:0]       speed;
    logic [LED_W-1:0] led;
    logic             tick;
    logic             dir;

    modport master (output mode, run, step, speed, input led, tick, dir);
    modport slave  (input mode, run, step, speed, output led, tick, dir);
endinterface

// File: rtl/led_pattern_seq_prescaler.sv
// Free-running tick prescaler: advance pulse every (TICK_DIV >> speed)
// cycles while run is high; counter cleared while run is low.
module tick_prescaler #(
    parameter int TICK_DIV = 6_000_000,
    parameter int CNT_W    = 24
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic [1:0] speed,
    output logic       adv_o
);
    localparam logic [CNT_W:0] DIV_FULL = (CNT_W+1)'(TICK_DIV);

    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   period_m1;
    logic             at_end;

    // >= rather than == so a speed-up mid-count fires on the very next cycle.
    always_comb begin
        period_m1 = (DIV_FULL >> speed) - (CNT_W+1)'(1);
        at_end    = ({1'b0, count} >= period_m1);
    end

    assign adv_o = run && at_end;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!run || at_end) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: rotate-left/right, bounce and binary count patterns
// with run/pause, single-step and speed select. Build option
// LED_SEQ_ACTIVE_LOW_EN inverts the led pins for active-low boards.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int LED_W    = 4,
    parameter int TICK_DIV = 6_000_000,
    parameter int CNT_W    = 24
) (
    input  logic               clock,
    input  logic               reset,
    led_pattern_seq_if.slave   bus
);
    mode_e            mode_q;
    logic [LED_W-1:0] pat;
    logic [LED_W-1:0] pat_nxt;
    logic [LED_W-1:0] seed_cur;
    logic             dir_q;
    logic             dir_nxt;
    logic             tick_q;
    logic             mode_chg;
    logic             pre_adv;
    logic             adv;
    logic             onehot;
    logic             up;

    assign mode_chg = (bus.mode != mode_q);
    assign seed_cur = LED_W'(led_seed(bus.mode, LED_W));

    // Holding the prescaler's run low on a mode change clears its count,
    // so the new pattern gets a full period before its first advance.
    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .run   (bus.run && !mode_chg),
        .speed (bus.speed),
        .adv_o (pre_adv)
    );

    assign adv = pre_adv || (!bus.run && bus.step && !mode_chg);

    always_comb begin
        pat_nxt = pat;
        dir_nxt = dir_q;
        up      = 1'b0;
        onehot  = (pat != '0) && ((pat & (pat - LED_W'(1))) == '0);
        case (mode_q)
            MODE_ROT_L:  pat_nxt = {pat[LED_W-2:0], pat[LED_W-1]};
            MODE_ROT_R:  pat_nxt = {pat[0], pat[LED_W-1:1]};
            MODE_BOUNCE: begin
                // Turn around when already sitting on the end we are heading for.
                up      = dir_q ? pat[0] : !pat[LED_W-1];
                pat_nxt = up ? (pat << 1) : (pat >> 1);
                dir_nxt = pat_nxt[LED_W-1] ? 1'b1 : (pat_nxt[0] ? 1'b0 : !up);
            end
            MODE_COUNT:  pat_nxt = pat + LED_W'(1);
        endcase
        if (mode_q != MODE_COUNT && !onehot) begin
            pat_nxt = seed_cur;
            dir_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pat    <= LED_W'(1);
            dir_q  <= 1'b0;
            tick_q <= 1'b0;
            mode_q <= MODE_ROT_L;
        end else begin
            mode_q <= mode_e'(bus.mode);
            tick_q <= adv;
            if (mode_chg) begin
                pat   <= seed_cur;
                dir_q <= 1'b0;
            end else if (adv) begin
                pat   <= pat_nxt;
                dir_q <= dir_nxt;
            end
        end
    end

`ifdef LED_SEQ_ACTIVE_LOW_EN
    assign bus.led = ~pat;
`else
    assign bus.led = pat;
`endif
    assign bus.tick = tick_q;
    assign bus.dir  = dir_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq: directed scenarios plus a random
// phase, all compared every cycle against a position-based reference model.
module tb_led_pattern_seq;
    localparam int LED_W    = 4;
    localparam int TICK_DIV = 8;
    localparam int CNT_W    = 24;
`ifdef LED_SEQ_ACTIVE_LOW_EN
    localparam logic [LED_W-1:0] INV = '1;
`else
    localparam logic [LED_W-1:0] INV = '0;
`endif
    localparam logic [LED_W-1:0] RST_LED = 4'b0001 ^ INV;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    led_pattern_seq_if #(.LED_W(LED_W)) bus ();

    led_pattern_seq #(
        .LED_W    (LED_W),
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: lit-LED position for rotate modes, phase in the
    // 2*LED_W-2 bounce cycle, integer value for count mode.
    int         m_cnt   = 0;
    int         m_pos   = 0;
    int         m_phase = 0;
    int         m_val   = 0;
    int         m_period;
    bit         m_adv;
    logic       m_tick  = 1'b0;
    logic [1:0] m_mode_q = 2'd0;

    function automatic logic [LED_W-1:0] exp_led();
        int idx;
        case (m_mode_q)
            2'd0, 2'd1: return LED_W'(1) << m_pos;
            2'd2: begin
                idx = (m_phase < LED_W) ? m_phase : (2*LED_W - 2 - m_phase);
                return LED_W'(1) << idx;
            end
            default: return LED_W'(m_val);
        endcase
    endfunction

    function automatic logic exp_dir();
        return (m_mode_q == 2'd2) && (m_phase >= LED_W - 1);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_cnt = 0; m_pos = 0; m_phase = 0; m_val = 0;
            m_tick = 1'b0; m_mode_q = 2'd0;
        end else begin
            m_period = TICK_DIV >> bus.speed;
            m_adv    = 1'b0;
            if (bus.mode != m_mode_q) begin
                m_cnt = 0; m_phase = 0; m_val = 0;
                m_pos = (bus.mode == 2'd1) ? LED_W - 1 : 0;
                m_tick = 1'b0;
            end else begin
                if (bus.run) begin
                    if (m_cnt >= m_period - 1) begin
                        m_adv = 1'b1;
                        m_cnt = 0;
                    end else begin
                        m_cnt++;
                    end
                end else begin
                    m_cnt = 0;
                    m_adv = bus.step;
                end
                if (m_adv) begin
                    case (m_mode_q)
                        2'd0:    m_pos   = (m_pos + 1) % LED_W;
                        2'd1:    m_pos   = (m_pos + LED_W - 1) % LED_W;
                        2'd2:    m_phase = (m_phase + 1) % (2*LED_W - 2);
                        default: m_val   = (m_val + 1) % (1 << LED_W);
                    endcase
                end
                m_tick = m_adv;
            end
            m_mode_q = bus.mode;
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            check_val("led", bus.led, exp_led() ^ INV);
            check_val("tick", bus.tick, m_tick);
            check_val("dir", bus.dir, exp_dir());
        end
    end

    task automatic wait_tick(output int n, input int limit);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.tick && n < limit);
        check_val("tick_seen", bus.tick, 1);
    endtask

    logic [LED_W-1:0] rotl_tbl [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [LED_W-1:0] bnc_tbl  [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                       4'b0010, 4'b0001, 4'b0010, 4'b0100};
    logic             bdir_tbl [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int n, ticks, guard;

    initial begin
        bus.mode = 2'd0; bus.run = 1'b1; bus.step = 1'b0; bus.speed = 2'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_val("rst_led", bus.led, RST_LED);
        check_val("rst_tick", bus.tick, 0);
        check_val("rst_dir", bus.dir, 0);
        chk_on = 1'b1;

        for (int i = 0; i < 4; i++) begin
            wait_tick(n, 20);
            check_val("rotl_gap", n, 8);
            check_val("rotl_led", bus.led ^ INV, rotl_tbl[i]);
        end

        bus.mode = 2'd2;
        @(negedge clock);
        check_val("bnc_seed", bus.led ^ INV, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            wait_tick(n, 20);
            check_val("bnc_led", bus.led ^ INV, bnc_tbl[i]);
            check_val("bnc_dir", bus.dir, bdir_tbl[i]);
        end

        bus.mode = 2'd3;
        for (int i = 0; i < 16; i++) wait_tick(n, 20);
        check_val("cnt_wrap", bus.led ^ INV, 4'b0000);
        bus.mode = 2'd1;
        @(negedge clock);
        check_val("rotr_seed", bus.led ^ INV, 4'b1000);
        check_val("rotr_notick", bus.tick, 0);
        wait_tick(n, 20);
        check_val("rotr_gap", n, 8);

        bus.mode = 2'd0;
        bus.run  = 1'b0;
        @(negedge clock);
        check_val("step_seed", bus.led ^ INV, 4'b0001);
        ticks = 0;
        for (int c = 0; c < 50; c++) begin
            bus.step = (c % 5 == 0) && (c < 15);
            @(negedge clock);
            if (bus.tick) ticks++;
        end
        bus.step = 1'b0;
        check_val("step_cnt", ticks, 3);
        check_val("step_led", bus.led ^ INV, 4'b1000);

        bus.run = 1'b1;
        guard = 0;
        while (m_cnt != 6 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check_val("spd_reach6", m_cnt, 6);
        bus.speed = 2'd3;
        @(negedge clock);
        check_val("spd_adv", bus.tick, 1);
        @(negedge clock);
        check_val("spd_p1a", bus.tick, 1);
        @(negedge clock);
        check_val("spd_p1b", bus.tick, 1);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) bus.mode  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) bus.run   = ~bus.run;
            if ($urandom_range(0, 29) == 0) bus.speed = 2'($urandom_range(0, 3));
            bus.step = ($urandom_range(0, 7) == 0);
            @(negedge clock);
        end
        bus.step = 1'b0; bus.run = 1'b1; bus.speed = 2'd0; bus.mode = 2'd2;

        guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (!(bus.dir && (bus.led ^ INV) == 4'b0100) && guard < 200);
        check_val("arst_pre_dir", bus.dir, 1);
        #2 reset = 1'b1;
        #1;
        check_val("arst_led", bus.led, RST_LED);
        check_val("arst_dir", bus.dir, 0);
        check_val("arst_tick", bus.tick, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got %0t limit 1000000", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
Parametrised successor to the board's single-pattern LED shifter. Drives LED_W LEDs from a prescaled tick, with four selectable patterns, run/pause, single-step and a 4-level speed select. Sits between the switch/button inputs and the LED pins of the board top level.

Parameters:
LED_W, 4, number of LEDs driven (legal range 2..16)
TICK_DIV, 6_000_000, base tick period in clock cycles (0.25 s at 24 MHz); legal range >= 8
CNT_W, 24, prescaler counter width; must hold TICK_DIV-1

Ports:
clock  in  1  system clock (24 MHz on board)
reset  in  1  asynchronous, active-high reset
mode   in  2  pattern select: 0 rotate-left, 1 rotate-right, 2 bounce, 3 binary count
run    in  1  1 = free-running on ticks; 0 = paused
step   in  1  single-cycle pulse, already synchronised and debounced; advances one pattern step when paused
speed  in  2  period = TICK_DIV >> speed (0 slowest, 3 = 8x faster)
led    out LED_W  pattern output, registered
tick   out 1  one-cycle pulse on every pattern advance (tick or step)
dir    out 1  bounce direction: 0 moving toward MSB, 1 moving toward LSB

Behaviour:
- Reset (async, active-high) values: prescaler count = 0; led = seed(mode sampled at reset release, otherwise LSB one-hot); tick = 0; dir = 0; mode_q = 0.
- Seeds: modes 0 and 2 -> LSB one-hot (…0001); mode 1 -> MSB one-hot (1000…); mode 3 -> all zero.
- Prescaler: when run = 1, count increments each cycle.
  - When count >= period-1: count <= 0 and an advance occurs. The period is exactly `period` cycles.
  - The >= compare means a speed increase mid-count advances on the next cycle.
  - When run = 0, count is held at 0.
- Advance: led takes its next value on the clock edge where the advance condition is true. tick = 1 in the cycle after that edge, coincident with the new led value. There is no extra output lag.
- Step: if run = 0 and step = 1, advance on that edge. step is ignored while run = 1.
- Next-value rules:
  - mode 0: rotate left; MSB wraps to LSB.
  - mode 1: rotate right; LSB wraps to MSB.
  - mode 2: one-hot bounce, no repeat at the ends. With LED_W = 4: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, …
    - dir flips in the same edge that moves led onto an end bit.
    - With LED_W = 2 it alternates 01, 10.
  - mode 3: led + 1, modulo 2^LED_W (wraps to 0).
- Mode change: mode_q registers mode every cycle. When mode != mode_q:
  - on that edge, led <= seed(mode), dir <= 0, count <= 0;
  - no tick is generated;
  - mode change wins over a simultaneous advance.
- Illegal one-hot recovery: in modes 0–2, if led is not one-hot (e.g. after a mode 3 → 0 glitch), the next advance loads the seed instead of the computed value.
- Reset mid-operation returns all state to the reset values immediately, regardless of pattern position.

Optional Feature:
LED_SEQ_ACTIVE_LOW_EN
- Defined: the led port drives the bitwise inverse of the internal pattern, for active-low LED boards. Reset value of led becomes the inverted seed. tick and dir are unaffected.
- Undefined: led is active-high as described above.

Decomposition:
- Package led_seq_pkg holds:
  - mode encoding constants: MODE_ROT_L = 2'd0, MODE_ROT_R = 2'd1, MODE_BOUNCE = 2'd2, MODE_COUNT = 2'd3;
  - a function returning seed(mode, LED_W).
- One sub-module, tick_prescaler (params TICK_DIV, CNT_W; ports clock, reset, run, speed, adv_o). It owns the counter and the >= compare.
- led_pattern_seq holds the pattern register, mode tracking and next-value logic.

Test Plan:
- Bench config: TICK_DIV = 8, LED_W = 4, speed = 0, run = 1, mode = 0.
  - After reset, led = 0001, then 0010, 0100, 1000, 0001, with advances every 8 cycles.
  - tick is high for exactly 1 cycle per advance.
- Mode 2: from 0001, over 8 advances observe 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100. dir = 1 from the 1000 step until the 0001 step.
- Mode 3 with LED_W = 4: 16 advances return led to 0000. Then switch to mode 1: led = 1000 next cycle, no tick pulse, and the next advance comes 8 cycles later.
- run = 0, three step pulses spaced 5 cycles apart in mode 0: led advances exactly three times, one cycle after each pulse. No free-running advance occurs over 50 cycles.
- speed 0 -> 3 while count = 6:
  - advance on the next cycle;
  - afterwards, period = 1 cycle (8 >> 3).
- Assert reset while led = 0100 in mode 2 with dir = 1: led = 0001, dir = 0 and tick = 0 immediately, without waiting for a clock edge. Repeat with LED_SEQ_ACTIVE_LOW_EN defined: led = 1110.
